l2_mshr_alloc: RTL and testbench
================================

Name: l2_mshr_alloc

Overview:
- Allocation and free-list tracker for the L2 MSHR. It sits directly upstream of the L2 global register block.
- Picks the lowest free MSHR entry for new misses and records each entry's set. Detects set conflicts against in-flight entries.
- Generates the single-cycle pulses the register block consumes: add_mshr_entry, incr_mshr_cnt, mshr_i, set_set_conflict and clr_set_conflict.

Parameters:
N_MSHR, 4, number of MSHR entries (power of two, ≥2)
MSHR_BITS, 2, log2(N_MSHR)
SET_BITS, 9, L2 set index width

Ports:
clk  in  1  clock
rst  in  1  reset
alloc_req  in  1  request a new MSHR entry this cycle
alloc_set  in  SET_BITS  set index of the allocating request
alloc_gnt  out  1  allocation accepted this cycle (combinational)
alloc_idx  out  MSHR_BITS  granted entry index (combinational; valid when alloc_gnt)
free_req  in  1  release entry free_idx (response written, entry cleared)
free_idx  in  MSHR_BITS  entry to release
lookup_valid  in  1  conflict lookup request
lookup_set  in  SET_BITS  set to check against valid entries
add_mshr_entry  out  1  registered pulse: net allocation occurred
incr_mshr_cnt  out  1  registered pulse: net free occurred
mshr_i  out  MSHR_BITS  registered index of the last accepted free
set_set_conflict  out  1  registered pulse: lookup hit a valid entry
clr_set_conflict  out  1  registered pulse: the entry blocking the conflict was freed
conflict_idx  out  MSHR_BITS  lowest matching entry of the last hitting lookup (held)
free_cnt  out  MSHR_BITS+1  number of free entries
full  out  1  free_cnt == 0
err_double_free  out  1  sticky: free of an invalid entry was seen

Behaviour:
- Reset is asynchronous and active-low on rst; clock is clk.
- Reset values: valid bitmap all 0; set store 0; free_cnt = N_MSHR; full 0; all pulses 0; mshr_i 0; conflict_idx 0; conflict_pending 0; err_double_free 0.
- Grant: alloc_gnt = alloc_req && !full.
- alloc_idx = lowest index whose valid bit is 0, computed from current registered state. There is no bypass of a same-cycle free.
- On a granted edge: valid[alloc_idx] ← 1 and set_q[alloc_idx] ← alloc_set.
- Accepted free: free_req && valid[free_idx]. On the edge, valid[free_idx] ← 0.
- Double free: free_req && !valid[free_idx]. It is ignored, with no pulse and no state change, and sets err_double_free (sticky until reset).
- Counter and pulses are driven by the net event, registered one cycle after the event:
  - grant only: free_cnt−1; add_mshr_entry=1 next cycle.
  - accepted free only: free_cnt+1; incr_mshr_cnt=1 next cycle; mshr_i ← free_idx.
  - both in the same cycle: free_cnt unchanged; neither add nor incr pulses; mshr_i ← free_idx still updates.
- The net-zero case is required because the downstream counter gives add priority over incr.
- free_cnt never wraps. A grant is impossible at 0; an accepted free is impossible at N_MSHR.
- Conflict lookup: the compare uses the registered valid and set_q only; an entry being allocated the same cycle is not matched.
  - hit = any valid[i] && set_q[i]==lookup_set.
  - On lookup_valid && hit: next cycle set_set_conflict=1 for one cycle; conflict_idx ← lowest hit index; conflict_pending ← 1.
  - On lookup_valid && !hit: no pulse; conflict state unchanged.
- Conflict release: when conflict_pending && accepted free with free_idx==conflict_idx, next cycle clr_set_conflict=1 for one cycle and conflict_pending ← 0.
- Simultaneous release and new hit: if the release and a new hitting lookup occur in the same cycle, both pulses fire. conflict_pending stays 1 and conflict_idx takes the new hit index.
- All pulses are exactly one cycle wide; back-to-back events produce back-to-back pulses.
- Reset asserted mid-operation returns everything to reset values immediately, including in-flight pulses.

Test Plan:
1. Reset, then 4 consecutive alloc_req (sets 0x10..0x13) → alloc_idx 0,1,2,3. add_mshr_entry pulses on cycles 2..5. free_cnt 4→0; full=1. A 5th alloc_req gives alloc_gnt=0 and no pulse.
2. Full state, free_req idx 2 → incr_mshr_cnt pulse next cycle, mshr_i=2, free_cnt=1. The next alloc gets alloc_idx=2.
3. With free_cnt=2, alloc_req and accepted free_req on idx 1 in the same cycle → no add or incr pulse, free_cnt stays 2, mshr_i=1. valid[1] is cleared and the new entry is set at the lowest free index (excluding 1).
4. Entries 0 (set 0x20) and 3 (set 0x55); lookup 0x55 → set_set_conflict pulse, conflict_idx=3. Lookup 0x77 → no pulse. Free idx 0 → no clr. Free idx 3 → clr_set_conflict pulse one cycle after.
5. free_req on invalid idx 1 → no incr pulse, free_cnt unchanged, err_double_free=1 and held.
6. Assert rst low while add_mshr_entry is pending and conflict_pending=1 → next cycle all outputs are at reset values: free_cnt=4, no pulses, err_double_free=0.

Source files
------------

// File: rtl/l2_mshr_alloc.sv
// L2 MSHR allocation / free-list tracker: lowest-free allocation, per-entry set store,
// set-conflict detection and the single-cycle pulses consumed by the L2 global register block.
module l2_mshr_alloc #(
  parameter int N_MSHR    = 4,
  parameter int MSHR_BITS = 2,
  parameter int SET_BITS  = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_req,
  input  logic [SET_BITS-1:0]  alloc_set,
  output logic                 alloc_gnt,
  output logic [MSHR_BITS-1:0] alloc_idx,
  input  logic                 free_req,
  input  logic [MSHR_BITS-1:0] free_idx,
  input  logic                 lookup_valid,
  input  logic [SET_BITS-1:0]  lookup_set,
  output logic                 add_mshr_entry,
  output logic                 incr_mshr_cnt,
  output logic [MSHR_BITS-1:0] mshr_i,
  output logic                 set_set_conflict,
  output logic                 clr_set_conflict,
  output logic [MSHR_BITS-1:0] conflict_idx,
  output logic [MSHR_BITS:0]   free_cnt,
  output logic                 full,
  output logic                 err_double_free
);

  localparam logic [MSHR_BITS:0] CNT_MAX = (MSHR_BITS+1)'(N_MSHR);

  logic [N_MSHR-1:0]   valid_q;
  logic [SET_BITS-1:0] set_q [N_MSHR];
  logic                conflict_pending;

  logic                 acc_free;
  logic                 dbl_free;
  logic                 hit;
  logic [MSHR_BITS-1:0] hit_idx;
  logic                 release_hit;

  assign full      = (free_cnt == '0);
  assign alloc_gnt = alloc_req && !full;
  assign acc_free  = free_req && valid_q[free_idx];
  assign dbl_free  = free_req && !valid_q[free_idx];

  // Descending scans so the lowest matching index wins.
  always_comb begin
    alloc_idx = '0;
    hit       = 1'b0;
    hit_idx   = '0;
    for (int i = N_MSHR - 1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_idx = MSHR_BITS'(i);
      if (valid_q[i] && (set_q[i] == lookup_set)) begin
        hit     = 1'b1;
        hit_idx = MSHR_BITS'(i);
      end
    end
  end

  assign release_hit = conflict_pending && acc_free && (free_idx == conflict_idx);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < N_MSHR; i++) set_q[i] <= '0;
    end else begin
      if (alloc_gnt) begin
        valid_q[alloc_idx] <= 1'b1;
        set_q[alloc_idx]   <= alloc_set;
      end
      // A granted index is never valid, so it cannot collide with an accepted free.
      if (acc_free) valid_q[free_idx] <= 1'b0;
    end
  end

  // Pulses reflect the net event: the downstream counter gives add priority over incr,
  // so a simultaneous grant and free must produce neither.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      free_cnt         <= CNT_MAX;
      add_mshr_entry   <= 1'b0;
      incr_mshr_cnt    <= 1'b0;
      mshr_i           <= '0;
      set_set_conflict <= 1'b0;
      clr_set_conflict <= 1'b0;
      conflict_idx     <= '0;
      conflict_pending <= 1'b0;
      err_double_free  <= 1'b0;
    end else begin
      add_mshr_entry <= alloc_gnt && !acc_free;
      incr_mshr_cnt  <= acc_free && !alloc_gnt;
      if (alloc_gnt && !acc_free)      free_cnt <= free_cnt - 1'b1;
      else if (acc_free && !alloc_gnt) free_cnt <= free_cnt + 1'b1;
      if (acc_free) mshr_i <= free_idx;

      set_set_conflict <= lookup_valid && hit;
      clr_set_conflict <= release_hit;
      if (lookup_valid && hit) begin
        conflict_idx     <= hit_idx;
        conflict_pending <= 1'b1;
      end else if (release_hit) begin
        conflict_pending <= 1'b0;
      end

      if (dbl_free) err_double_free <= 1'b1;
    end
  end

endmodule

// File: tb/tb_l2_mshr_alloc.sv
// Directed bench for l2_mshr_alloc: allocation order, net-event pulses, conflict tracking,
// double-free detection and asynchronous reset.
module tb_l2_mshr_alloc;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       alloc_req = 1'b0;
  logic [8:0] alloc_set = '0;
  logic       alloc_gnt;
  logic [1:0] alloc_idx;
  logic       free_req = 1'b0;
  logic [1:0] free_idx = '0;
  logic       lookup_valid = 1'b0;
  logic [8:0] lookup_set = '0;
  logic       add_mshr_entry;
  logic       incr_mshr_cnt;
  logic [1:0] mshr_i;
  logic       set_set_conflict;
  logic       clr_set_conflict;
  logic [1:0] conflict_idx;
  logic [2:0] free_cnt;
  logic       full;
  logic       err_double_free;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  l2_mshr_alloc #(.N_MSHR(4), .MSHR_BITS(2), .SET_BITS(9)) dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_set(alloc_set),
    .alloc_gnt(alloc_gnt), .alloc_idx(alloc_idx),
    .free_req(free_req), .free_idx(free_idx),
    .lookup_valid(lookup_valid), .lookup_set(lookup_set),
    .add_mshr_entry(add_mshr_entry), .incr_mshr_cnt(incr_mshr_cnt), .mshr_i(mshr_i),
    .set_set_conflict(set_set_conflict), .clr_set_conflict(clr_set_conflict),
    .conflict_idx(conflict_idx), .free_cnt(free_cnt), .full(full),
    .err_double_free(err_double_free)
  );

  // Advance to just after the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_req = 1'b0;
    free_req = 1'b0;
    lookup_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic alloc_one(input logic [8:0] s);
    alloc_req = 1'b1;
    alloc_set = s;
    tick();
    alloc_req = 1'b0;
  endtask

  task automatic free_one(input logic [1:0] idx);
    free_req = 1'b1;
    free_idx = idx;
    tick();
    free_req = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (free_cnt !== 3'd4) begin errors++; $display("FAIL reset_free_cnt got %0d exp 4", free_cnt); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b exp 0", full); end
    checks++; if ({add_mshr_entry, incr_mshr_cnt, set_set_conflict, clr_set_conflict} !== 4'b0)
      begin errors++; $display("FAIL reset_pulses got %b exp 0000", {add_mshr_entry, incr_mshr_cnt, set_set_conflict, clr_set_conflict}); end
    checks++; if ({mshr_i, conflict_idx, err_double_free} !== 5'b0)
      begin errors++; $display("FAIL reset_regs got %b exp 00000", {mshr_i, conflict_idx, err_double_free}); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      alloc_req = 1'b1;
      alloc_set = 9'h10 + 9'(i);
      #1;
      checks++; if (alloc_gnt !== 1'b1) begin errors++; $display("FAIL fill_gnt[%0d] got %0b exp 1", i, alloc_gnt); end
      checks++; if (alloc_idx !== 2'(i)) begin errors++; $display("FAIL fill_idx[%0d] got %0d exp %0d", i, alloc_idx, i); end
      tick();
      checks++; if (add_mshr_entry !== 1'b1) begin errors++; $display("FAIL fill_add[%0d] got %0b exp 1", i, add_mshr_entry); end
      checks++; if (free_cnt !== 3'(3 - i)) begin errors++; $display("FAIL fill_cnt[%0d] got %0d exp %0d", i, free_cnt, 3 - i); end
    end
    alloc_set = 9'h99;
    #1;
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag got %0b exp 1", full); end
    checks++; if (alloc_gnt !== 1'b0) begin errors++; $display("FAIL full_gnt got %0b exp 0", alloc_gnt); end
    tick();
    alloc_req = 1'b0;
    checks++; if (add_mshr_entry !== 1'b0) begin errors++; $display("FAIL full_add got %0b exp 0", add_mshr_entry); end
    checks++; if (free_cnt !== 3'd0) begin errors++; $display("FAIL full_cnt got %0d exp 0", free_cnt); end
  endtask

  task automatic test_free_realloc();
    free_one(2'd2);
    checks++; if (incr_mshr_cnt !== 1'b1) begin errors++; $display("FAIL free_incr got %0b exp 1", incr_mshr_cnt); end
    checks++; if (mshr_i !== 2'd2) begin errors++; $display("FAIL free_mshr_i got %0d exp 2", mshr_i); end
    checks++; if (free_cnt !== 3'd1) begin errors++; $display("FAIL free_cnt got %0d exp 1", free_cnt); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL free_full got %0b exp 0", full); end
    alloc_req = 1'b1;
    alloc_set = 9'h12;
    #1;
    checks++; if (alloc_idx !== 2'd2) begin errors++; $display("FAIL realloc_idx got %0d exp 2", alloc_idx); end
    tick();
    alloc_req = 1'b0;
    checks++; if (incr_mshr_cnt !== 1'b0) begin errors++; $display("FAIL realloc_incr got %0b exp 0", incr_mshr_cnt); end
    checks++; if (free_cnt !== 3'd0) begin errors++; $display("FAIL realloc_cnt got %0d exp 0", free_cnt); end
  endtask

  task automatic test_net_zero();
    // All four valid; free 0 then 3 back to back leaves entries 1 and 2 valid.
    free_req = 1'b1;
    free_idx = 2'd0;
    tick();
    free_idx = 2'd3;
    checks++; if (incr_mshr_cnt !== 1'b1) begin errors++; $display("FAIL b2b_incr0 got %0b exp 1", incr_mshr_cnt); end
    tick();
    free_req = 1'b0;
    checks++; if (incr_mshr_cnt !== 1'b1) begin errors++; $display("FAIL b2b_incr1 got %0b exp 1", incr_mshr_cnt); end
    checks++; if (free_cnt !== 3'd2) begin errors++; $display("FAIL b2b_cnt got %0d exp 2", free_cnt); end
    alloc_req = 1'b1;
    alloc_set = 9'h33;
    free_req = 1'b1;
    free_idx = 2'd1;
    #1;
    checks++; if (alloc_idx !== 2'd0) begin errors++; $display("FAIL net_idx got %0d exp 0", alloc_idx); end
    tick();
    idle();
    checks++; if ({add_mshr_entry, incr_mshr_cnt} !== 2'b00) begin errors++; $display("FAIL net_pulses got %b exp 00", {add_mshr_entry, incr_mshr_cnt}); end
    checks++; if (free_cnt !== 3'd2) begin errors++; $display("FAIL net_cnt got %0d exp 2", free_cnt); end
    checks++; if (mshr_i !== 2'd1) begin errors++; $display("FAIL net_mshr_i got %0d exp 1", mshr_i); end
    alloc_req = 1'b1;
    #1;
    checks++; if (alloc_idx !== 2'd1) begin errors++; $display("FAIL net_next_idx got %0d exp 1", alloc_idx); end
    alloc_req = 1'b0;
  endtask

  task automatic test_conflict();
    do_reset();
    alloc_one(9'h020);
    alloc_one(9'h011);
    alloc_one(9'h022);
    alloc_one(9'h055);
    free_one(2'd1);
    free_one(2'd2);
    lookup_valid = 1'b1;
    lookup_set = 9'h055;
    tick();
    lookup_valid = 1'b0;
    checks++; if (set_set_conflict !== 1'b1) begin errors++; $display("FAIL conf_set got %0b exp 1", set_set_conflict); end
    checks++; if (conflict_idx !== 2'd3) begin errors++; $display("FAIL conf_idx got %0d exp 3", conflict_idx); end
    tick();
    checks++; if (set_set_conflict !== 1'b0) begin errors++; $display("FAIL conf_set_width got %0b exp 0", set_set_conflict); end
    lookup_valid = 1'b1;
    lookup_set = 9'h077;
    tick();
    lookup_valid = 1'b0;
    checks++; if (set_set_conflict !== 1'b0) begin errors++; $display("FAIL conf_miss got %0b exp 0", set_set_conflict); end
    checks++; if (conflict_idx !== 2'd3) begin errors++; $display("FAIL conf_miss_idx got %0d exp 3", conflict_idx); end
    free_one(2'd0);
    checks++; if (clr_set_conflict !== 1'b0) begin errors++; $display("FAIL conf_other_clr got %0b exp 0", clr_set_conflict); end
    free_one(2'd3);
    checks++; if (clr_set_conflict !== 1'b1) begin errors++; $display("FAIL conf_clr got %0b exp 1", clr_set_conflict); end
    tick();
    checks++; if (clr_set_conflict !== 1'b0) begin errors++; $display("FAIL conf_clr_width got %0b exp 0", clr_set_conflict); end
  endtask

  task automatic test_double_free();
    free_one(2'd1);
    checks++; if (incr_mshr_cnt !== 1'b0) begin errors++; $display("FAIL dbl_incr got %0b exp 0", incr_mshr_cnt); end
    checks++; if (free_cnt !== 3'd4) begin errors++; $display("FAIL dbl_cnt got %0d exp 4", free_cnt); end
    checks++; if (err_double_free !== 1'b1) begin errors++; $display("FAIL dbl_err got %0b exp 1", err_double_free); end
    tick();
    tick();
    checks++; if (err_double_free !== 1'b1) begin errors++; $display("FAIL dbl_sticky got %0b exp 1", err_double_free); end
  endtask

  task automatic test_reset_mid();
    alloc_one(9'h055);
    alloc_req = 1'b1;
    alloc_set = 9'h066;
    lookup_valid = 1'b1;
    lookup_set = 9'h055;
    tick();
    idle();
    checks++; if ({add_mshr_entry, set_set_conflict} !== 2'b11) begin errors++; $display("FAIL mid_pre got %b exp 11", {add_mshr_entry, set_set_conflict}); end
    rst = 1'b0;
    #1;
    checks++; if ({add_mshr_entry, set_set_conflict} !== 2'b00) begin errors++; $display("FAIL mid_async_pulses got %b exp 00", {add_mshr_entry, set_set_conflict}); end
    tick();
    checks++; if (free_cnt !== 3'd4) begin errors++; $display("FAIL mid_cnt got %0d exp 4", free_cnt); end
    checks++; if ({add_mshr_entry, incr_mshr_cnt, set_set_conflict, clr_set_conflict, full} !== 5'b0)
      begin errors++; $display("FAIL mid_flags got %b exp 00000", {add_mshr_entry, incr_mshr_cnt, set_set_conflict, clr_set_conflict, full}); end
    checks++; if (err_double_free !== 1'b0) begin errors++; $display("FAIL mid_err got %0b exp 0", err_double_free); end
    rst = 1'b1;
    // Cleared conflict state: a lookup of the old set must now miss.
    lookup_valid = 1'b1;
    lookup_set = 9'h055;
    tick();
    lookup_valid = 1'b0;
    checks++; if (set_set_conflict !== 1'b0) begin errors++; $display("FAIL mid_lookup got %0b exp 0", set_set_conflict); end
  endtask

  initial begin
    #1;
    test_reset();
    test_fill();
    test_free_realloc();
    test_net_zero();
    test_conflict();
    test_double_free();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
